// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-drive FSM with per-key press/release debounce,
// producing a hex key code, a one-cycle valid strobe and a held flag.
module keypad_scanner #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] col_idx,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        case (rows)
            4'b1110: low_index = 2'd0;
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  4'hF: key_map = 4'hD;
            default: key_map = 4'h0;
        endcase
    endfunction

    logic [3:0]    sync1_r, sync2_r, cap_rows_r, cap_rows_s;
    logic [1:0]    cap_row_r, cap_row_s, col_idx_r, col_idx_s;
    logic [SW-1:0] slot_r, slot_s;
    logic [DW-1:0] deb_r, deb_s;
    state_t        state_r, state_s;
    logic [3:0]    col_n_r, key_code_r, key_code_s;
    logic          key_valid_r, key_valid_s, key_held_r, key_held_s;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= row_n;
            sync2_r <= sync1_r;
        end
    end

    // Next-state logic; everything holds while scan_en is low
    always_comb begin
        state_s    = state_r;
        slot_s     = slot_r;
        deb_s      = deb_r;
        col_idx_s  = col_idx_r;
        cap_rows_s = cap_rows_r;
        cap_row_s  = cap_row_r;
        if (scan_en) begin
            case (state_r)
                ST_SCAN: begin
                    if (slot_r == SLOT_LAST) begin
                        slot_s = {SW{1'b0}};
                        if (single_low(sync2_r)) begin
                            state_s    = ST_DEBOUNCE;
                            deb_s      = {DW{1'b0}};
                            cap_rows_s = sync2_r;
                            cap_row_s  = low_index(sync2_r);
                        end else begin
                            col_idx_s = col_idx_r + 2'd1;
                        end
                    end else begin
                        slot_s = slot_r + SLOT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (sync2_r != cap_rows_r) begin
                        state_s   = ST_SCAN;
                        slot_s    = {SW{1'b0}};
                        col_idx_s = col_idx_r + 2'd1;
                    end else if (deb_r == DEB_LAST) begin
                        state_s = ST_PRESSED;
                    end else begin
                        deb_s = deb_r + DEB_ONE;
                    end
                end
                ST_PRESSED: begin
                    state_s = ST_RELEASE;
                    deb_s   = {DW{1'b0}};
                end
                ST_RELEASE: begin
                    // Any low row (including a second key) restarts the release count
                    if (sync2_r != 4'b1111) begin
                        deb_s = {DW{1'b0}};
                    end else if (deb_r == DEB_LAST) begin
                        state_s   = ST_SCAN;
                        slot_s    = {SW{1'b0}};
                        col_idx_s = col_idx_r + 2'd1;
                    end else begin
                        deb_s = deb_r + DEB_ONE;
                    end
                end
                default: begin
                    state_s = ST_SCAN;
                    slot_s  = {SW{1'b0}};
                    deb_s   = {DW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output next values: the pulse is emitted from PRESSED only on an enabled cycle
    always_comb begin
        key_valid_s = 1'b0;
        key_code_s  = key_code_r;
        key_held_s  = key_held_r;
        if (scan_en && (state_r == ST_PRESSED)) begin
            key_valid_s = 1'b1;
            key_code_s  = key_map(cap_row_r, col_idx_r);
            key_held_s  = 1'b1;
        end else if (scan_en && (state_r == ST_RELEASE) && (state_s == ST_SCAN)) begin
            key_held_s = 1'b0;
        end else begin
            key_held_s = key_held_r;
        end
    end

    // State, counter and registered output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_SCAN;
            slot_r      <= {SW{1'b0}};
            deb_r       <= {DW{1'b0}};
            col_idx_r   <= 2'd0;
            col_n_r     <= 4'b1110;
            cap_rows_r  <= 4'b1111;
            cap_row_r   <= 2'd0;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            slot_r      <= slot_s;
            deb_r       <= deb_s;
            col_idx_r   <= col_idx_s;
            col_n_r     <= ~(4'b0001 << col_idx_s);
            cap_rows_r  <= cap_rows_s;
            cap_row_r   <= cap_row_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    assign col_n     = col_n_r;
    assign col_idx   = col_idx_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a combinational keypad matrix model driven by
// col_n, a table of single-key presses, and hand-written multi-cycle corner cases.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst_n, scan_en;
    logic [3:0] row_n, col_n, key_code;
    logic [1:0] col_idx;
    logic       key_valid, key_held;
    logic [15:0] keys;
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row_n(row_n),
        .col_n(col_n), .col_idx(col_idx), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) if (key_valid === 1'b1) pulses++;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input string name, input logic [3:0] code);
        int n = 0;
        while (key_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, {31'd0, key_valid}, 32'd1);
        chk({name, "_code"}, {28'd0, key_code}, {28'd0, code});
        chk({name, "_held"}, {31'd0, key_held}, 32'd1);
        @(negedge clk);
        chk({name, "_single"}, {31'd0, key_valid}, 32'd0);
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        while (key_held !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_released"}, {31'd0, key_held}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0, ci, n1, n2;
        logic [3:0] frozen;
        bit frozen_ok;
        vecs[0] = '{1, 2, 4'h6};
        vecs[1] = '{0, 0, 4'h1};
        vecs[2] = '{3, 3, 4'hD};
        vecs[3] = '{3, 0, 4'hE};
        vecs[4] = '{2, 1, 4'h8};
        vecs[5] = '{0, 3, 4'hA};
        vecs[6] = '{3, 1, 4'h0};
        vecs[7] = '{3, 2, 4'hF};

        rst_n = 1'b0; scan_en = 1'b1; keys = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_col_n", {28'd0, col_n}, 32'he);
        chk("rst_col_idx", {30'd0, col_idx}, 32'd0);
        chk("rst_key_code", {28'd0, key_code}, 32'd0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_key_held", {31'd0, key_held}, 32'd0);

        // Idle scan: a new column every 4 cycles, wrapping
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("scan_c0", {28'd0, col_n}, 32'he);
        repeat (4) @(negedge clk);
        chk("scan_c1", {28'd0, col_n}, 32'hd);
        repeat (4) @(negedge clk);
        chk("scan_c2", {28'd0, col_n}, 32'hb);
        repeat (4) @(negedge clk);
        chk("scan_c3", {28'd0, col_n}, 32'h7);
        repeat (4) @(negedge clk);
        chk("scan_wrap", {28'd0, col_n}, 32'he);
        chk("scan_no_pulse", pulses, 32'd0);

        // Single-key table
        for (int i = 0; i < 8; i++) begin
            p0 = pulses;
            keys[vecs[i].r*4+vecs[i].c] = 1'b1;
            wait_pulse($sformatf("key_r%0dc%0d", vecs[i].r, vecs[i].c), vecs[i].code);
            repeat (10) @(negedge clk);
            keys = 16'h0000;
            wait_release($sformatf("key_r%0dc%0d", vecs[i].r, vecs[i].c));
            chk($sformatf("next_col_r%0dc%0d", vecs[i].r, vecs[i].c), {30'd0, col_idx},
                (vecs[i].c + 1) % 4);
            chk($sformatf("held_code_r%0dc%0d", vecs[i].r, vecs[i].c), {28'd0, key_code},
                {28'd0, vecs[i].code});
            chk($sformatf("one_pulse_r%0dc%0d", vecs[i].r, vecs[i].c), pulses - p0, 32'd1);
        end

        // Bounce on key 1 for 30 cycles, then stable
        p0 = pulses;
        for (int t = 0; t < 10; t++) begin
            keys[0] = (t % 2 == 0);
            repeat (3) @(negedge clk);
        end
        chk("bounce_no_pulse", pulses - p0, 32'd0);
        keys[0] = 1'b1;
        wait_pulse("bounce", 4'h1);
        keys = 16'h0000;
        wait_release("bounce");

        // Ghost: rows 0 and 2 in column 1 never accepted, scan keeps advancing
        p0 = pulses;
        keys[0*4+1] = 1'b1;
        keys[2*4+1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ci = col_idx;
            repeat (4) @(negedge clk);
            chk("ghost_advance", {30'd0, col_idx}, (ci + 1) % 4);
        end
        chk("ghost_no_pulse", pulses - p0, 32'd0);
        keys = 16'h0000;
        repeat (20) @(negedge clk);

        // Second key while D is held is ignored
        keys[15] = 1'b1;
        wait_pulse("hold_d", 4'hD);
        p0 = pulses;
        keys[5] = 1'b1;
        repeat (20) @(negedge clk);
        keys[5] = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_d_still", {31'd0, key_held}, 32'd1);
        keys[15] = 1'b0;
        wait_release("hold_d");
        repeat (60) @(negedge clk);
        chk("no_pulse_for_5", pulses - p0, 32'd0);
        chk("code_stays_d", {28'd0, key_code}, 32'hd);

        // Baseline latency from reset release with key 1 already down
        keys[0] = 1'b1;
        do_reset();
        n1 = 0;
        while (key_valid !== 1'b1 && n1 < 100) begin
            @(negedge clk);
            n1++;
        end
        chk("baseline_in_bound", {31'd0, (n1 <= 27)}, 32'd1);
        chk("baseline_code", {28'd0, key_code}, 32'h1);

        // Same press with scan_en low for 20 cycles inside DEBOUNCE
        do_reset();
        n2 = 0;
        frozen = 4'hx;
        frozen_ok = 1'b1;
        while (key_valid !== 1'b1 && n2 < 200) begin
            @(negedge clk);
            n2++;
            if (n2 == 6) begin
                scan_en = 1'b0;
                frozen = col_n;
            end else if (n2 > 6 && n2 <= 26) begin
                if (col_n !== frozen || key_valid !== 1'b0) frozen_ok = 1'b0;
                if (n2 == 26) scan_en = 1'b1;
            end
        end
        chk("stall_col_frozen", {31'd0, frozen_ok}, 32'd1);
        chk("stall_delay", n2 - n1, 32'd20);
        chk("stall_code", {28'd0, key_code}, 32'h1);

        // Asynchronous reset while in RELEASE, then re-detection of the held key
        repeat (4) @(negedge clk);
        chk("pre_rst_held", {31'd0, key_held}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_col_n", {28'd0, col_n}, 32'he);
        chk("arst_col_idx", {30'd0, col_idx}, 32'd0);
        chk("arst_key_code", {28'd0, key_code}, 32'd0);
        chk("arst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("arst_key_held", {31'd0, key_held}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pulse("redetect", 4'h1);
        keys = 16'h0000;
        wait_release("redetect");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
